gray_count_decoder: RTL
=======================

# gray_count_decoder

Downstream consumer of the 8-bit Gray-coded counter. Samples the Gray count, converts it to binary, and checks that successive samples advance by exactly 0 or +1 (mod 2^WIDTH). Outputs the decoded value with a valid strobe, flags wrap-around and illegal steps, and tracks lock status with a saturating error counter. Feeds binary count and health flags to the status/telemetry logic.

## Interface
- WIDTH, 8, width of Gray input and binary output
- ERR_LIMIT, 4, consecutive step errors (1..255) that force loss of lock
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset; one clock; all state cleared on assertion
- gray_in  input  WIDTH  Gray-coded count from the counter stage
- sample_en  input  1  capture gray_in at this edge when high
- bin_out  output  WIDTH  decoded binary of last capture; reset 0
- bin_valid  output  1  one-cycle pulse per decoded sample; reset 0
- wrap  output  1  one-cycle pulse: previous 2^WIDTH-1, current 0; reset 0
- step_err  output  1  one-cycle pulse: illegal step while locked; reset 0
- locked  output  1  high in LOCKED state; reset 0
- err_count  output  8  total step errors, saturates at 255; reset 0

## Operation
- Stage 1: on edge with sample_en=1, register gray_in into g_q; set s1_valid. s1_valid clears on any edge with sample_en=0.
- Stage 2: b = Gray-to-binary(g_q): b[WIDTH-1]=g[WIDTH-1], b[i]=b[i+1]^g[i]. Registered into bin_out when s1_valid; bin_out holds otherwise.
- delta = (b - prev) mod 2^WIDTH, prev = last decoded value (internal, reset 0).
- FSM states: IDLE (reset state), LOCKED.
- IDLE: first s1_valid sample loads prev=b, bin_valid=1, no check, move to LOCKED at same edge.
- LOCKED, per s1_valid sample: delta=0 -> legal hold; delta=1 -> legal advance, wrap=1 if prev=2^WIDTH-1 and b=0; other delta -> step_err=1, err_count+=1 (sat 255), consec_err+=1. Legal sample clears consec_err. prev=b on every sample, legal or not.
- consec_err reaching ERR_LIMIT -> go to IDLE at that edge, clear consec_err; err_count retained. Next sample re-locks.
- wrap and step_err mutually exclusive; never asserted without bin_valid.
- Flags only produced from s1_valid; no spurious pulses from idle cycles.

## Timing
- Capture at edge k (sample_en=1) -> bin_out, bin_valid, wrap, step_err, locked, err_count updated at edge k+1. Latency 1 cycle after capture (2 with sync, below).
- Back-to-back sample_en every cycle supported: one bin_valid per cycle, full throughput.
- Pulses last exactly one cycle unless the next sample also produces them.
- reset asserted mid-operation: all outputs and state to reset values immediately (asynchronously); in-flight stage-1 sample discarded; first sample after release handled as IDLE (no error).
- Deassertion of reset: first edge after release may capture.

## Configuration
- GRAY_DEC_INPUT_SYNC_EN defined: gray_in passes through a 2-flop synchronizer (reset 0) before stage 1, and sample_en is delayed by 2 flops to match; latency from gray_in change to bin_valid = 3 edges. For Gray inputs originating in another clock domain.
- Undefined: no synchronizer; behaviour as in Timing (latency 1 after capture).

## Test plan
- Reset then sample_en held high, gray_in driven with Gray of 0,1,2,...,255,0,1 -> bin_out follows 0..255,0,1 one cycle later; locked=1 after first sample; wrap pulses exactly once (255->0); step_err never; err_count=0.
- Locked at binary 10, feed Gray of 10 twice then 11 -> delta 0 legal, no step_err; bin_out 10,10,11.
- Locked at 20, feed Gray of 25 -> step_err=1 one cycle, err_count=1; then Gray of 26 -> legal, consec_err clears, locked stays 1.
- ERR_LIMIT=4, feed 4 consecutive illegal jumps (binary 0,50,100,150,200) -> 4 step_err pulses, locked drops on 4th; next sample 201 -> relock, no step_err, err_count=4.
- Assert reset for 1 cycle mid-stream with sample_en high -> all outputs 0 asynchronously, no bin_valid for discarded sample, first post-reset sample of any value locks without error.
- With GRAY_DEC_INPUT_SYNC_EN: single sample of Gray(0x5A) -> bin_valid and bin_out=0x5A exactly 3 edges after drive; without macro -> 1 edge after capture.

Source files
------------

// File: rtl/gray_count_decoder.sv
// Gray-to-binary decoder with step checking, wrap detection and lock tracking.
// Optional macro GRAY_DEC_INPUT_SYNC_EN adds an input synchronizer for cross-domain Gray inputs.
`timescale 1ns/1ps

module gray_count_decoder #(
  parameter int WIDTH     = 8,
  parameter int ERR_LIMIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             sample_en,
  output logic [WIDTH-1:0] bin_out,
  output logic             bin_valid,
  output logic             wrap,
  output logic             step_err,
  output logic             locked,
  output logic [7:0]       err_count
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] MAX_VAL = '1;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [7:0]       LIMIT   = 8'(ERR_LIMIT);

  logic [WIDTH-1:0] g_reg;
  logic             s1_valid_reg;

`ifdef GRAY_DEC_INPUT_SYNC_EN
  // First synchronizer flop is free-running; stage 1 acts as the second flop,
  // so gray_in change to bin_valid spans three edges.
  logic [WIDTH-1:0] sync_reg;
  logic             se_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg     <= '0;
      se_reg       <= 1'b0;
      g_reg        <= '0;
      s1_valid_reg <= 1'b0;
    end else begin
      sync_reg     <= gray_in;
      se_reg       <= sample_en;
      s1_valid_reg <= se_reg;
      if (se_reg)
        g_reg <= sync_reg;
    end
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      g_reg        <= '0;
      s1_valid_reg <= 1'b0;
    end else begin
      s1_valid_reg <= sample_en;
      if (sample_en)
        g_reg <= gray_in;
    end
  end
`endif

  // Each binary bit is the XOR of all Gray bits at or above it.
  logic [WIDTH-1:0] bin_dec;
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_dec
      assign bin_dec[gi] = ^g_reg[WIDTH-1:gi];
    end
  endgenerate

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] prev_reg, prev_next;
  logic [7:0]       consec_reg, consec_next;
  logic [7:0]       err_reg, err_next;
  logic [WIDTH-1:0] bin_reg, bin_next;
  logic             valid_reg, valid_next;
  logic             wrap_reg, wrap_next;
  logic             step_reg, step_next;
  logic [WIDTH-1:0] delta;

  assign delta = bin_dec - prev_reg;

  always_comb begin
    state_next  = state_reg;
    prev_next   = prev_reg;
    consec_next = consec_reg;
    err_next    = err_reg;
    bin_next    = bin_reg;
    valid_next  = 1'b0;
    wrap_next   = 1'b0;
    step_next   = 1'b0;
    if (s1_valid_reg) begin
      bin_next   = bin_dec;
      valid_next = 1'b1;
      prev_next  = bin_dec;
      case (state_reg)
        IDLE: begin
          state_next  = LOCKED;
          consec_next = '0;
        end
        LOCKED: begin
          if (delta == '0 || delta == ONE) begin
            consec_next = '0;
            wrap_next   = (prev_reg == MAX_VAL) && (bin_dec == '0);
          end else begin
            step_next = 1'b1;
            if (err_reg != 8'hFF)
              err_next = err_reg + 8'd1;
            // consec_reg stays below LIMIT, so the increment cannot overflow
            if (consec_reg + 8'd1 >= LIMIT) begin
              state_next  = IDLE;
              consec_next = '0;
            end else begin
              consec_next = consec_reg + 8'd1;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      prev_reg   <= '0;
      consec_reg <= '0;
      err_reg    <= '0;
      bin_reg    <= '0;
      valid_reg  <= 1'b0;
      wrap_reg   <= 1'b0;
      step_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      prev_reg   <= prev_next;
      consec_reg <= consec_next;
      err_reg    <= err_next;
      bin_reg    <= bin_next;
      valid_reg  <= valid_next;
      wrap_reg   <= wrap_next;
      step_reg   <= step_next;
    end
  end

  assign bin_out   = bin_reg;
  assign bin_valid = valid_reg;
  assign wrap      = wrap_reg;
  assign step_err  = step_reg;
  assign locked    = (state_reg == LOCKED);
  assign err_count = err_reg;

endmodule
